// File: rtl/vga_frame_receiver.sv
// vga_frame_receiver: sink side of the on-board VGA controller. Samples HS/VS/colour,
// regenerates pixel coordinates from the sync edges, checks sync timing against the
// configured raster (640x480 by default), and reports lock and timing errors.
// Optional per-frame CRC-16-CCITT of the visible pixels when VGA_RX_CRC_EN is defined;
// without it FRAME_CRC is tied to zero and no CRC logic is built.
//
// state  | meaning
// SEARCH | waiting for the first HS falling edge
// HSYNC  | line timing seen, waiting for a VS falling edge
// VSYNC  | frame start seen, checking one full frame before declaring lock
// LOCK   | tracking a valid frame, LOCKED=1
module vga_frame_receiver #(
   parameter int H_VIS = 640,
   parameter int H_FP  = 16,
   parameter int H_SW  = 96,
   parameter int H_BP  = 48,
   parameter int V_VIS = 480,
   parameter int V_FP  = 10,
   parameter int V_SW  = 2,
   parameter int V_BP  = 33
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        PIX_TICK,
   input  logic        HS,
   input  logic        VS,
   input  logic [11:0] COLOR_IN,
   output logic        LOCKED,
   output logic [9:0]  RX_X,
   output logic [9:0]  RX_Y,
   output logic        RX_VALID,
   output logic [11:0] RX_COLOR,
   output logic        FRAME_DONE,
   output logic        H_ERR,
   output logic        V_ERR,
   output logic [7:0]  ERR_CNT,
   output logic [15:0] FRAME_CRC
);

   localparam int          H_TOT    = H_VIS + H_FP + H_SW + H_BP;
   localparam int          V_TOT    = V_VIS + V_FP + V_SW + V_BP;
   localparam logic [9:0]  H_LAST   = 10'(H_TOT - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
   localparam logic [9:0]  H_SYNC_X = 10'(H_VIS + H_FP);
   localparam logic [9:0]  V_SYNC_Y = 10'(V_VIS + V_FP);
   localparam logic [9:0]  H_VIS_C  = 10'(H_VIS);
   localparam logic [9:0]  V_VIS_C  = 10'(V_VIS);
   localparam logic [10:0] H_SW_C   = 11'(H_SW);
   localparam logic [10:0] V_SW_C   = 11'(V_SW);

   typedef enum logic [1:0] {SEARCH, HSYNC, VSYNC, LOCK} state_t;

   state_t      state, state_nx;
   logic        hs_prev, vs_prev;
   logic        hs_fall, hs_rise, vs_fall, vs_rise;
   logic        h_wrap, checking;
   logic [9:0]  h_pred, v_pred, h_nx, v_nx;
   logic [10:0] hs_w, hs_w_nx;
   logic [9:0]  vs_w, vs_w_nx;
   logic [10:0] vs_rise_w;
   logic        h_err_nx, v_err_nx, valid_nx;
   logic [8:0]  err_sum;
   logic [7:0]  err_nx;

   // Edge detection, free-running coordinate prediction, sync checks and next state.
   always_comb begin
      hs_fall   = hs_prev & ~HS;
      hs_rise   = ~hs_prev & HS;
      vs_fall   = vs_prev & ~VS;
      vs_rise   = ~vs_prev & VS;
      h_wrap    = (RX_X == H_LAST);
      h_pred    = h_wrap ? 10'd0 : RX_X + 10'd1;
      v_pred    = RX_Y;
      if (h_wrap)
         v_pred = (RX_Y == V_LAST) ? 10'd0 : RX_Y + 10'd1;
      h_nx      = hs_fall ? H_SYNC_X : h_pred;
      v_nx      = vs_fall ? V_SYNC_Y : v_pred;

      // HS width in ticks, including the falling-edge sample; held once HS is high.
      hs_w_nx   = hs_w;
      if (hs_fall)
         hs_w_nx = 11'd1;
      else if (!HS && hs_w != 11'h7FF)
         hs_w_nx = hs_w + 11'd1;

      // VS width in completed lines; the line ending on the rise tick still counts.
      vs_w_nx   = vs_w;
      if (vs_fall)
         vs_w_nx = 10'd0;
      else if (!VS && h_wrap && vs_w != 10'h3FF)
         vs_w_nx = vs_w + 10'd1;
      vs_rise_w = {1'b0, vs_w} + 11'(h_wrap);

      checking  = (state == VSYNC) || (state == LOCK);
      h_err_nx  = checking && ((hs_fall && h_pred != H_SYNC_X) ||
                               (hs_rise && hs_w != H_SW_C));
      v_err_nx  = checking && ((vs_fall && v_pred != V_SYNC_Y) ||
                               (vs_rise && vs_rise_w != V_SW_C));

      state_nx  = state;
      case (state)
         SEARCH: if (hs_fall) state_nx = HSYNC;
         HSYNC:  if (vs_fall) state_nx = VSYNC;
         VSYNC:  if (h_err_nx || v_err_nx) state_nx = SEARCH;
                 else if (vs_fall)         state_nx = LOCK;
         LOCK:   if (h_err_nx || v_err_nx) state_nx = SEARCH;
         default: state_nx = SEARCH;
      endcase

      valid_nx  = (state_nx == LOCK) && (h_nx < H_VIS_C) && (v_nx < V_VIS_C);
      err_sum   = {1'b0, ERR_CNT} + 9'(h_err_nx) + 9'(v_err_nx);
      err_nx    = err_sum[8] ? 8'hFF : err_sum[7:0];
   end

   // Tick-qualified register update; pulse outputs drop on any non-tick edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= SEARCH;
         hs_prev    <= 1'b0;
         vs_prev    <= 1'b0;
         hs_w       <= '0;
         vs_w       <= '0;
         LOCKED     <= 1'b0;
         RX_X       <= '0;
         RX_Y       <= '0;
         RX_VALID   <= 1'b0;
         RX_COLOR   <= '0;
         FRAME_DONE <= 1'b0;
         H_ERR      <= 1'b0;
         V_ERR      <= 1'b0;
         ERR_CNT    <= '0;
      end else if (PIX_TICK) begin
         state      <= state_nx;
         hs_prev    <= HS;
         vs_prev    <= VS;
         hs_w       <= hs_w_nx;
         vs_w       <= vs_w_nx;
         LOCKED     <= (state_nx == LOCK);
         RX_X       <= h_nx;
         RX_Y       <= v_nx;
         RX_VALID   <= valid_nx;
         RX_COLOR   <= COLOR_IN;
         FRAME_DONE <= vs_fall && (state == LOCK);
         H_ERR      <= h_err_nx;
         V_ERR      <= v_err_nx;
         ERR_CNT    <= err_nx;
      end else begin
         FRAME_DONE <= 1'b0;
         H_ERR      <= 1'b0;
         V_ERR      <= 1'b0;
      end
   end

`ifdef VGA_RX_CRC_EN
   logic [15:0] crc, crc_base;
   logic        frame_ok;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [11:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 11; i >= 0; i--)
         r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
      return r;
   endfunction

   // The VS fall closes a frame: restart from the init value for the next one.
   always_comb crc_base = vs_fall ? 16'hFFFF : crc;

   // Running CRC over visible locked pixels; publish only frames that stayed locked.
   always_ff @(posedge CLK) begin
      if (RST) begin
         crc       <= 16'hFFFF;
         frame_ok  <= 1'b0;
         FRAME_CRC <= '0;
      end else if (PIX_TICK) begin
         if (vs_fall) begin
            if (frame_ok && state_nx == LOCK)
               FRAME_CRC <= crc;
            frame_ok <= (state_nx == LOCK);
         end else begin
            frame_ok <= frame_ok && (state_nx == LOCK);
         end
         crc <= valid_nx ? crc_step(crc_base, COLOR_IN) : crc_base;
      end
   end
`else
   assign FRAME_CRC = '0;
`endif

endmodule
